// File: rtl/jahangir_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices, forward
// select codes and the bit layout of one scoreboard entry.
package jahangir_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int NUM_STG   = 5;

    // Scoreboard slots, youngest first.
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;
    localparam int NUM_SB = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Entry layout, LSB first: is_load, wr_address[ADDR_W], wr_enable, valid.
    localparam int SB_LD       = 0;
    localparam int SB_ADDR_LSB = 1;

    function automatic int sb_we_bit(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int sb_vld_bit(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int sb_width(input int addr_w);
        return addr_w + 3;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and hazard-control response bundle between the pipeline
// (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int MC_W   = 5,
    parameter int PERF_W = 16
);
    logic              in_id_reg1_enable;
    logic [ADDR_W-1:0] in_id_reg1_address;
    logic              in_id_reg2_enable;
    logic [ADDR_W-1:0] in_id_reg2_address;
    logic              in_id_wr_enable;
    logic [ADDR_W-1:0] in_id_wr_address;
    logic              in_id_is_load;
    logic              in_id_mc;
    logic [MC_W-1:0]   in_id_mc_cycles;
    logic              in_flush;

    logic [4:0]        out_stall;
    logic [4:0]        out_flush;
    logic [1:0]        out_fwd_sel1;
    logic [1:0]        out_fwd_sel2;
    logic              out_mc_busy;
    logic [PERF_W-1:0] out_stall_cycles;

    modport master (
        output in_id_reg1_enable, in_id_reg1_address, in_id_reg2_enable, in_id_reg2_address,
               in_id_wr_enable, in_id_wr_address, in_id_is_load, in_id_mc, in_id_mc_cycles,
               in_flush,
        input  out_stall, out_flush, out_fwd_sel1, out_fwd_sel2, out_mc_busy, out_stall_cycles
    );

    modport slave (
        input  in_id_reg1_enable, in_id_reg1_address, in_id_reg2_enable, in_id_reg2_address,
               in_id_wr_enable, in_id_wr_address, in_id_is_load, in_id_mc, in_id_mc_cycles,
               in_flush,
        output out_stall, out_flush, out_fwd_sel1, out_fwd_sel2, out_mc_busy, out_stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// One decode source compared against the ex/mem/wb scoreboard entries; yields the
// per-entry match vector and the youngest-wins forward select.
module hazard_cmp
    import jahangir_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int SB_W   = ADDR_W + 3,
    parameter int FWD_EN = 1
) (
    input  logic                        src_en,
    input  logic [ADDR_W-1:0]           src_addr,
    input  logic [NUM_SB-1:0][SB_W-1:0] sb,
    output logic [NUM_SB-1:0]           match,
    output logic [1:0]                  fwd_sel
);
    localparam int VLD_B = sb_vld_bit(ADDR_W);
    localparam int WE_B  = sb_we_bit(ADDR_W);

    logic src_live;

    // r0 is hard-wired zero, so reading it never depends on an in-flight write.
    assign src_live = src_en & (src_addr != '0);

    for (genvar s = 0; s < NUM_SB; s++) begin : g_ent
        assign match[s] = src_live & sb[s][VLD_B] & sb[s][WE_B]
                        & (sb[s][SB_ADDR_LSB +: ADDR_W] == src_addr);
    end

    always_comb begin
        fwd_sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (match[SB_EX])       fwd_sel = FWD_EX;
            else if (match[SB_MEM]) fwd_sel = FWD_MEM;
            else if (match[SB_WB])  fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for the 5-stage core: tracks in-flight writes
// in ex/mem/wb, drives forward selects and per-register hold/bubble controls.
module pipe_hazard_ctrl
    import jahangir_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int MC_W   = 5,
    parameter int FWD_EN = 1,
    parameter int PERF_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SB_W = sb_width(ADDR_W);

    logic [NUM_SB-1:0][SB_W-1:0] sb_q;
    logic [MC_W-1:0]             mc_cnt_q;
    logic [PERF_W-1:0]           perf_q;

    logic [1:0]                  src_en;
    logic [1:0][ADDR_W-1:0]      src_addr;
    logic [1:0][NUM_SB-1:0]      match;
    logic [1:0][1:0]             sel;

    logic [SB_W-1:0]             id_ent;
    logic                        mc_active, ld_use, raw, hazard, id_move, mc_load;
    logic [NUM_STG-1:0]          stall, flush;

    assign src_en   = {bus.in_id_reg2_enable, bus.in_id_reg1_enable};
    assign src_addr = {bus.in_id_reg2_address, bus.in_id_reg1_address};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_cmp #(
            .ADDR_W (ADDR_W),
            .SB_W   (SB_W),
            .FWD_EN (FWD_EN)
        ) u_cmp (
            .src_en   (src_en[g]),
            .src_addr (src_addr[g]),
            .sb       (sb_q),
            .match    (match[g]),
            .fwd_sel  (sel[g])
        );
    end

    assign id_ent    = {1'b1, bus.in_id_wr_enable, bus.in_id_wr_address, bus.in_id_is_load};
    assign mc_active = (mc_cnt_q != '0);

    // With forwarding only a load still in ex is unresolvable; without it any
    // pending write must drain through wb first.
    assign ld_use = sb_q[SB_EX][SB_LD] & (match[0][SB_EX] | match[1][SB_EX]);
    assign raw    = |match;
    assign hazard = (FWD_EN != 0) ? ld_use : raw;

    always_comb begin
        stall = '0;
        flush = '0;
        if (bus.in_flush) begin
            flush[STG_IFID]  = 1'b1;
            flush[STG_IDEX]  = 1'b1;
            flush[STG_EXMEM] = mc_active;
        end else if (mc_active) begin
            stall[STG_PC]    = 1'b1;
            stall[STG_IFID]  = 1'b1;
            stall[STG_IDEX]  = 1'b1;
            flush[STG_EXMEM] = 1'b1;
        end else if (hazard) begin
            stall[STG_PC]    = 1'b1;
            stall[STG_IFID]  = 1'b1;
            flush[STG_IDEX]  = 1'b1;
        end
    end

    assign id_move = ~(stall[STG_IDEX] | flush[STG_IDEX]);
    assign mc_load = bus.in_id_mc & (bus.in_id_mc_cycles > MC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q     <= '0;
            mc_cnt_q <= '0;
            perf_q   <= '0;
        end else begin
            sb_q[SB_WB] <= sb_q[SB_MEM];
            if (flush[STG_EXMEM])      sb_q[SB_MEM] <= '0;
            else if (!stall[STG_EXMEM]) sb_q[SB_MEM] <= sb_q[SB_EX];
            if (flush[STG_IDEX])       sb_q[SB_EX] <= '0;
            else if (!stall[STG_IDEX]) sb_q[SB_EX] <= id_ent;

            // Countdown holds the op in ex for cycles-1 extra edges; a redirect aborts it.
            if (bus.in_flush)          mc_cnt_q <= '0;
            else if (mc_active)        mc_cnt_q <= mc_cnt_q - MC_W'(1);
            else if (id_move && mc_load) mc_cnt_q <= bus.in_id_mc_cycles - MC_W'(1);

            if (stall[STG_PC] && (perf_q != '1)) perf_q <= perf_q + PERF_W'(1);
        end
    end

    // Outputs are forced quiet during reset even though in_flush is a live input.
    assign bus.out_stall        = rst_n ? stall : '0;
    assign bus.out_flush        = rst_n ? flush : '0;
    assign bus.out_fwd_sel1     = rst_n ? sel[0] : '0;
    assign bus.out_fwd_sel2     = rst_n ? sel[1] : '0;
    assign bus.out_mc_busy      = rst_n & mc_active;
    assign bus.out_stall_cycles = rst_n ? perf_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controllers (forwarding, no forwarding, 4-bit perf counter)
// driven with the same decode stream and checked against an instruction-flow model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(5), .MC_W(5), .PERF_W(16)) bf ();
    pipe_hazard_ctrl_if #(.ADDR_W(5), .MC_W(5), .PERF_W(16)) bn ();
    pipe_hazard_ctrl_if #(.ADDR_W(5), .MC_W(5), .PERF_W(4))  bs ();

    pipe_hazard_ctrl #(.ADDR_W(5), .MC_W(5), .FWD_EN(1), .PERF_W(16))
        u_fwd (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
    pipe_hazard_ctrl #(.ADDR_W(5), .MC_W(5), .FWD_EN(0), .PERF_W(16))
        u_nofwd (.clk(clk), .rst_n(rst_n), .bus(bn.slave));
    pipe_hazard_ctrl #(.ADDR_W(5), .MC_W(5), .FWD_EN(1), .PERF_W(4))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

    typedef struct packed {
        bit r1e; bit [4:0] r1a; bit r2e; bit [4:0] r2a;
        bit we;  bit [4:0] wa;  bit ld;  bit mc; bit [4:0] mcc; bit fl;
    } stim_t;

    typedef struct packed {
        logic [4:0] stall; logic [4:0] flush; logic [1:0] s1; logic [1:0] s2;
        logic busy; logic [15:0] perf;
    } exp_t;

    typedef struct packed { bit v; bit we; bit ld; bit [4:0] addr; } rec_t;

    // Model 0 forwards, model 1 does not. Slot 0 = ex (youngest), 1 = mem, 2 = wb.
    rec_t m_st   [2][3];
    int   m_cnt  [2];
    int   m_perf [2];

    exp_t q_f[$];
    exp_t q_n[$];
    int   total = 0;
    int   bad   = 0;

    function automatic stim_t mk(input int r1e, input int r1a, input int r2e, input int r2a,
                                 input int we, input int wa, input int ld = 0,
                                 input int mc = 0, input int mcc = 0, input int fl = 0);
        stim_t s;
        s.r1e = 1'(r1e); s.r1a = 5'(r1a); s.r2e = 1'(r2e); s.r2a = 5'(r2a);
        s.we  = 1'(we);  s.wa  = 5'(wa);  s.ld  = 1'(ld);  s.mc  = 1'(mc);
        s.mcc = 5'(mcc); s.fl  = 1'(fl);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bf.in_id_reg1_enable = s.r1e; bn.in_id_reg1_enable = s.r1e; bs.in_id_reg1_enable = s.r1e;
        bf.in_id_reg1_address = s.r1a; bn.in_id_reg1_address = s.r1a; bs.in_id_reg1_address = s.r1a;
        bf.in_id_reg2_enable = s.r2e; bn.in_id_reg2_enable = s.r2e; bs.in_id_reg2_enable = s.r2e;
        bf.in_id_reg2_address = s.r2a; bn.in_id_reg2_address = s.r2a; bs.in_id_reg2_address = s.r2a;
        bf.in_id_wr_enable = s.we; bn.in_id_wr_enable = s.we; bs.in_id_wr_enable = s.we;
        bf.in_id_wr_address = s.wa; bn.in_id_wr_address = s.wa; bs.in_id_wr_address = s.wa;
        bf.in_id_is_load = s.ld; bn.in_id_is_load = s.ld; bs.in_id_is_load = s.ld;
        bf.in_id_mc = s.mc; bn.in_id_mc = s.mc; bs.in_id_mc = s.mc;
        bf.in_id_mc_cycles = s.mcc; bn.in_id_mc_cycles = s.mcc; bs.in_id_mc_cycles = s.mcc;
        bf.in_flush = s.fl; bn.in_flush = s.fl; bs.in_flush = s.fl;
    endtask

    // Expected outputs for this cycle, then advance the instruction flow by one edge.
    task automatic step_model(input int d, input stim_t s, input bit in_rst, output exp_t e);
        bit [1:0] sel [2];
        bit [4:0] src [2];
        bit       en  [2];
        bit       hit, ld_hit;
        bit [4:0] st, fl;
        rec_t     issued;
        src[0] = s.r1a; src[1] = s.r2a; en[0] = s.r1e; en[1] = s.r2e;
        hit = 0; ld_hit = 0;
        for (int k = 0; k < 2; k++) begin
            sel[k] = 0;
            for (int a = 2; a >= 0; a--) begin
                if (en[k] && src[k] != 0 && m_st[d][a].v && m_st[d][a].we && m_st[d][a].addr == src[k]) begin
                    hit = 1;
                    if (a == 0 && m_st[d][0].ld) ld_hit = 1;
                    if (d == 0) sel[k] = 2'(a + 1);
                end
            end
        end
        st = 0; fl = 0;
        if (s.fl)                         fl = (m_cnt[d] > 0) ? 5'b01110 : 5'b00110;
        else if (m_cnt[d] > 0)            begin st = 5'b00111; fl = 5'b01000; end
        else if (d == 0 ? ld_hit : hit)   begin st = 5'b00011; fl = 5'b00100; end

        e = '0;
        if (!in_rst) begin
            e.stall = st; e.flush = fl; e.s1 = sel[0]; e.s2 = sel[1];
            e.busy = (m_cnt[d] > 0); e.perf = 16'(m_perf[d]);
        end

        issued = '{v: 1'b1, we: s.we, ld: s.ld, addr: s.wa};
        if (in_rst) begin
            for (int a = 0; a < 3; a++) m_st[d][a] = '0;
            m_cnt[d] = 0; m_perf[d] = 0;
        end else begin
            m_st[d][2] = m_st[d][1];
            if (s.fl) begin
                m_st[d][1] = (m_cnt[d] > 0) ? rec_t'(0) : m_st[d][0];
                m_st[d][0] = '0;
                m_cnt[d] = 0;
            end else if (m_cnt[d] > 0) begin
                m_st[d][1] = '0;
                m_cnt[d]--;
            end else if (st[0]) begin
                m_st[d][1] = m_st[d][0];
                m_st[d][0] = '0;
            end else begin
                m_st[d][1] = m_st[d][0];
                m_st[d][0] = issued;
                m_cnt[d] = (s.mc && s.mcc >= 2) ? int'(s.mcc) - 1 : 0;
            end
            m_perf[d] += int'(st[0]);
        end
    endtask

    task automatic cycle(input stim_t s, input bit rst_v = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        apply(s);
        step_model(0, s, !rst_v, e); q_f.push_back(e);
        step_model(1, s, !rst_v, e); q_n.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q_f.size() != 0) begin
            e = q_f.pop_front();
            chk("fwd.stall", 32'(bf.out_stall), 32'(e.stall));
            chk("fwd.flush", 32'(bf.out_flush), 32'(e.flush));
            chk("fwd.sel1",  32'(bf.out_fwd_sel1), 32'(e.s1));
            chk("fwd.sel2",  32'(bf.out_fwd_sel2), 32'(e.s2));
            chk("fwd.busy",  32'(bf.out_mc_busy), 32'(e.busy));
            chk("fwd.perf",  32'(bf.out_stall_cycles), 32'(e.perf));
            chk("sat.stall", 32'(bs.out_stall), 32'(e.stall));
            chk("sat.perf",  32'(bs.out_stall_cycles), (e.perf > 15) ? 32'd15 : 32'(e.perf));
        end
        if (q_n.size() != 0) begin
            e = q_n.pop_front();
            chk("nofwd.stall", 32'(bn.out_stall), 32'(e.stall));
            chk("nofwd.flush", 32'(bn.out_flush), 32'(e.flush));
            chk("nofwd.sel1",  32'(bn.out_fwd_sel1), 32'(e.s1));
            chk("nofwd.sel2",  32'(bn.out_fwd_sel2), 32'(e.s2));
            chk("nofwd.busy",  32'(bn.out_mc_busy), 32'(e.busy));
            chk("nofwd.perf",  32'(bn.out_stall_cycles), 32'(e.perf));
        end
    end

    initial begin
        stim_t nop;
        nop = mk(0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 3; a++) m_st[d][a] = '0;
            m_cnt[d] = 0; m_perf[d] = 0;
        end
        apply(nop);

        // Reset with live inputs must keep every output at zero.
        cycle(mk(1, 3, 1, 4, 1, 3, 0, 0, 0, 1), 1'b0);
        cycle(nop, 1'b0);

        // Back-to-back ALU: ex, then mem, then wb forwarding of r3.
        cycle(mk(0, 0, 0, 0, 1, 3));
        cycle(mk(1, 3, 0, 0, 0, 0));
        cycle(mk(1, 3, 0, 0, 0, 0));
        cycle(mk(1, 3, 0, 0, 0, 0));
        cycle(nop);

        // Load-use on source 2.
        cycle(mk(0, 0, 0, 0, 1, 5, 1));
        cycle(mk(0, 0, 1, 5, 0, 0));
        cycle(mk(0, 0, 1, 5, 0, 0));
        cycle(nop);

        // r0 is never a hazard.
        cycle(mk(0, 0, 0, 0, 1, 0, 1));
        cycle(mk(1, 0, 1, 0, 0, 0));
        cycle(nop);

        // Four-cycle ex op, then drain.
        cycle(mk(0, 0, 0, 0, 1, 9, 0, 1, 4));
        for (int i = 0; i < 5; i++) cycle(mk(1, 9, 0, 0, 0, 0));

        // Redirect while two countdown cycles remain.
        cycle(mk(0, 0, 0, 0, 1, 10, 0, 1, 4));
        cycle(nop);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) cycle(mk(1, 10, 0, 0, 0, 0));

        // ALU r7 then repeated readers: no-forward controller stalls until wb retires.
        cycle(mk(0, 0, 0, 0, 1, 7));
        for (int i = 0; i < 5; i++) cycle(mk(1, 7, 0, 0, 0, 0));

        // Repeated dependent loads drive the 4-bit counter into saturation.
        for (int i = 0; i < 40; i++) cycle(mk(0, 0, 1, 5, 1, 5, 1));
        cycle(nop);

        // Reset in the middle of a countdown.
        cycle(mk(0, 0, 0, 0, 1, 11, 0, 1, 4));
        cycle(nop);
        cycle(mk(1, 11, 1, 11, 0, 0, 0, 0, 0, 1), 1'b0);
        cycle(nop, 1'b0);
        cycle(nop);
        cycle(mk(1, 11, 0, 0, 0, 0));

        // Random decode stream over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s.r1e = 1'($urandom_range(0, 1)); s.r1a = 5'($urandom_range(0, 7));
            s.r2e = 1'($urandom_range(0, 1)); s.r2a = 5'($urandom_range(0, 7));
            s.we  = 1'($urandom_range(0, 3) != 0); s.wa = 5'($urandom_range(0, 7));
            s.ld  = 1'($urandom_range(0, 3) == 0);
            s.mc  = 1'($urandom_range(0, 11) == 0); s.mcc = 5'($urandom_range(0, 6));
            s.fl  = 1'($urandom_range(0, 14) == 0);
            cycle(s);
        end

        cycle(nop);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
